// File: rtl/bp_pkg.sv
// Shared types and constants for the fetch-side branch predictor.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } bp_ctr_t;

  localparam bp_ctr_t     BP_CTR_RESET = WNT;
  localparam bp_ctr_t     BP_CTR_ALLOC = WT;
  localparam int unsigned PC_STEP      = 4;

endpackage

// File: rtl/bp_sat_counter.sv
// 2-bit saturating direction counter: next state from current state and outcome.
module bp_sat_counter
  import bp_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);

  // Step toward the resolved direction, holding at the strong ends.
  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != ST) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != SNT) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: 2-bit BHT for direction, tagged direct-mapped BTB
// for target. Zero-latency lookup, trained from the execute-stage outcome, with
// a registered one-cycle redirect on misprediction and saturating statistics.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int IDX_BITS = 6,
  parameter int TAG_BITS = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] FetchPC,
  output logic            PredHit,
  output logic            PredTaken,
  output logic [XLEN-1:0] PredTarget,
  input  logic            ExValid,
  input  logic            ExIsBranch,
  input  logic [XLEN-1:0] ExPC,
  input  logic [XLEN-1:0] ExTarget,
  input  logic            ExTaken,
  input  logic            ExPredTaken,
  input  logic [XLEN-1:0] ExPredTarget,
  output logic            Redirect,
  output logic [XLEN-1:0] RedirectPC,
  output logic [31:0]     BranchCount,
  output logic [31:0]     MispredCount
);

  localparam int ENTRIES = 1 << IDX_BITS;

  // Flop-array tables; valid and counter fields are control and get reset,
  // tag and target are only meaningful behind a valid bit.
  logic                btb_valid  [ENTRIES];
  logic [TAG_BITS-1:0] btb_tag    [ENTRIES];
  logic [XLEN-1:0]     btb_target [ENTRIES];
  logic [1:0]          bht_ctr    [ENTRIES];

  logic [IDX_BITS-1:0] fetch_idx;
  logic [TAG_BITS-1:0] fetch_tag;
  logic [IDX_BITS-1:0] ex_idx;
  logic [TAG_BITS-1:0] ex_tag;
  logic                update;
  logic                ex_hit;
  logic                mispredict;
  logic [1:0]          ctr_next;
  logic [XLEN-1:0]     ex_fallthrough;

  function automatic logic [31:0] sat_inc32(input logic [31:0] value, input logic en);
    sat_inc32 = (en && (value != 32'hFFFF_FFFF)) ? value + 32'd1 : value;
  endfunction

  assign fetch_idx      = FetchPC[IDX_BITS+1:2];
  assign fetch_tag      = FetchPC[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign ex_idx         = ExPC[IDX_BITS+1:2];
  assign ex_tag         = ExPC[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign update         = ExValid && ExIsBranch;
  assign ex_hit         = btb_valid[ex_idx] && (btb_tag[ex_idx] == ex_tag);
  assign ex_fallthrough = ExPC + XLEN'(PC_STEP);
  assign mispredict     = update && ((ExTaken != ExPredTaken) ||
                                     (ExTaken && (ExPredTarget != ExTarget)));

  bp_sat_counter u_sat_counter (
    .ctr      (bht_ctr[ex_idx]),
    .taken    (ExTaken),
    .ctr_next (ctr_next)
  );

  // Combinational lookup from the registered tables; no same-cycle bypass.
  always_comb begin
    PredHit    = btb_valid[fetch_idx] && (btb_tag[fetch_idx] == fetch_tag);
    PredTaken  = PredHit && bht_ctr[fetch_idx][1];
    PredTarget = PredTaken ? btb_target[fetch_idx] : FetchPC + XLEN'(PC_STEP);
  end

  // Train the tables on a resolved branch; reset wins over any pending update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_valid[i] <= 1'b0;
        bht_ctr[i]   <= BP_CTR_RESET;
      end
    end else if (update) begin
      if (ex_hit) begin
        bht_ctr[ex_idx] <= ctr_next;
        if (ExTaken) btb_target[ex_idx] <= ExTarget;
      end else if (ExTaken) begin
        btb_valid[ex_idx]  <= 1'b1;
        btb_tag[ex_idx]    <= ex_tag;
        btb_target[ex_idx] <= ExTarget;
        bht_ctr[ex_idx]    <= BP_CTR_ALLOC;
      end
    end
  end

  // Registered redirect pulse and saturating branch/mispredict statistics.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Redirect     <= 1'b0;
      RedirectPC   <= '0;
      BranchCount  <= '0;
      MispredCount <= '0;
    end else begin
      Redirect     <= mispredict;
      RedirectPC   <= ExTaken ? ExTarget : ex_fallthrough;
      BranchCount  <= sat_inc32(BranchCount, update);
      MispredCount <= sat_inc32(MispredCount, mispredict);
    end
  end

endmodule
